// File: rtl/asymfifo_s1_unpack.sv
// Single-clock width-down FIFO: whole wide words are stored, and each pop returns one
// narrow subword. The head entry is retired only after its last subword has been popped.
module asymfifo_s1_unpack #(
    parameter int data_in_width  = 16,
    parameter int data_out_width = 8,
    parameter int depth          = 8,
    parameter int err_mode       = 0,
    parameter int rst_mode       = 0,
    parameter int byte_order     = 0,
    localparam int K             = data_in_width / data_out_width,
    localparam int SW            = $clog2(K),
    localparam int AW            = $clog2(depth)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_req,
    input  logic                      pop_req,
    input  logic [data_in_width-1:0]  data_in,
    input  logic [AW-1:0]             ae_level,
    input  logic [AW-1:0]             af_thresh,
    output logic                      empty,
    output logic                      almost_empty,
    output logic                      half_full,
    output logic                      almost_full,
    output logic                      full,
    output logic                      error,
    output logic                      part_wd,
    output logic [data_out_width-1:0] data_out
);

    logic [data_in_width-1:0] mem_r [depth];
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            rd_ptr_r;
    logic [AW:0]              count_r;
    logic [SW-1:0]            sel_r;
    logic                     error_r;

    logic                     full_s;
    logic                     empty_s;
    logic                     push_ok_s;
    logic                     pop_ok_s;
    logic                     pop_last_s;
    logic                     bad_req_s;
    logic [data_in_width-1:0] head_s;
    logic [AW-1:0]            wr_ptr_nxt_s;
    logic [AW-1:0]            rd_ptr_nxt_s;

    // Accept/reject decisions use only registered occupancy, so a same-cycle pop never frees room for a push.
    always_comb begin
        full_s       = (count_r == (AW+1)'(depth));
        empty_s      = (count_r == '0);
        push_ok_s    = push_req && !full_s;
        pop_ok_s     = pop_req && !empty_s;
        pop_last_s   = pop_ok_s && (sel_r == SW'(K - 1));
        bad_req_s    = (push_req && full_s) || (pop_req && empty_s);
        wr_ptr_nxt_s = (wr_ptr_r == AW'(depth - 1)) ? '0 : wr_ptr_r + AW'(1);
        rd_ptr_nxt_s = (rd_ptr_r == AW'(depth - 1)) ? '0 : rd_ptr_r + AW'(1);
    end

    // Status flags decoded from registered count and subword index.
    always_comb begin
        empty        = empty_s;
        full         = full_s;
        almost_empty = (count_r <= {1'b0, ae_level});
        almost_full  = (count_r >= {1'b0, af_thresh});
        half_full    = (count_r >= (AW+1)'((depth + 1) / 2));
        part_wd      = (sel_r != '0);
        error        = error_r;
    end

    // Zero-latency head read; subword order chosen by byte_order.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (byte_order == 0) begin
            data_out = head_s[(K - 1 - int'(sel_r)) * data_out_width +: data_out_width];
        end else begin
            data_out = head_s[int'(sel_r) * data_out_width +: data_out_width];
        end
    end

    // Storage array; optionally cleared on reset.
    always_ff @(posedge clk) begin
        if (rst && (rst_mode == 0)) begin
            for (int i = 0; i < depth; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s && !rst) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy, subword index and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            sel_r    <= '0;
            error_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_nxt_s;
            end
            if (pop_last_s) begin
                sel_r    <= '0;
                rd_ptr_r <= rd_ptr_nxt_s;
            end else if (pop_ok_s) begin
                sel_r <= sel_r + SW'(1);
            end
            case ({push_ok_s, pop_last_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
            if (err_mode == 0) begin
                error_r <= error_r | bad_req_s;
            end else begin
                error_r <= bad_req_s;
            end
        end
    end

endmodule

// File: tb/tb_asymfifo_s1_unpack.sv
// Directed bench: two instances share stimulus, one with defaults (sticky error, MS subword first,
// storage cleared on reset) and one with err_mode=1, byte_order=1, rst_mode=1.
module tb_asymfifo_s1_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_req;
    logic        pop_req;
    logic [15:0] data_in;
    logic [2:0]  ae_level = 3'd2;
    logic [2:0]  af_thresh = 3'd6;

    logic e0, ae0, hf0, af0, f0, err0, pw0;
    logic e1, ae1, hf1, af1, f1, err1, pw1;
    logic [7:0] do0, do1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    asymfifo_s1_unpack u0 (
        .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req), .data_in(data_in),
        .ae_level(ae_level), .af_thresh(af_thresh), .empty(e0), .almost_empty(ae0),
        .half_full(hf0), .almost_full(af0), .full(f0), .error(err0), .part_wd(pw0),
        .data_out(do0)
    );

    asymfifo_s1_unpack #(.err_mode(1), .rst_mode(1), .byte_order(1)) u1 (
        .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req), .data_in(data_in),
        .ae_level(ae_level), .af_thresh(af_thresh), .empty(e1), .almost_empty(ae1),
        .half_full(hf1), .almost_full(af1), .full(f1), .error(err1), .part_wd(pw1),
        .data_out(do1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; push_req = 1'b0; pop_req = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        data_in = 16'h0000;
        do_reset();
        step();
        chk("rst_empty", e0, 1'b1);
        chk("rst_ae", ae0, 1'b1);
        chk("rst_hf", hf0, 1'b0);
        chk("rst_af", af0, 1'b0);
        chk("rst_full", f0, 1'b0);
        chk("rst_err", err0, 1'b0);
        chk("rst_part", pw0, 1'b0);
        chk("rst_dout", do0, 8'h00);

        // 1: single word, both subword orders
        push_req = 1'b1; data_in = 16'hA1B2;
        step();
        push_req = 1'b0;
        chk("t1_empty", e0, 1'b0);
        chk("t1_d0_a", do0, 8'hA1);
        chk("t1_d1_a", do1, 8'hB2);
        chk("t1_part_a", pw0, 1'b0);
        pop_req = 1'b1;
        step();
        chk("t1_d0_b", do0, 8'hB2);
        chk("t1_d1_b", do1, 8'hA1);
        chk("t1_part_b", pw0, 1'b1);
        chk("t1_part1_b", pw1, 1'b1);
        step();
        pop_req = 1'b0;
        chk("t1_empty_end", e0, 1'b1);
        chk("t1_empty1_end", e1, 1'b1);
        chk("t1_part_end", pw0, 1'b0);
        chk("t1_err", err0, 1'b0);

        // 2: fill to full, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            push_req = 1'b1; data_in = 16'h0100 + 16'(i);
            step();
            chk("t2_ae", ae0, (i + 1) <= 2);
            chk("t2_hf", hf0, (i + 1) >= 4);
            chk("t2_af", af0, (i + 1) >= 6);
            chk("t2_full", f0, (i + 1) == 8);
        end
        data_in = 16'hDEAD;
        step();
        push_req = 1'b0;
        chk("t2_ovf_err0", err0, 1'b1);
        chk("t2_ovf_err1", err1, 1'b1);
        chk("t2_ovf_full", f0, 1'b1);
        step();
        chk("t2_sticky0", err0, 1'b1);
        chk("t2_clear1", err1, 1'b0);
        pop_req = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("t2_d0_hi", do0, 8'h01);
            chk("t2_d1_lo", do1, 8'(j));
            chk("t2_part_hi", pw0, 1'b0);
            step();
            chk("t2_d0_lo", do0, 8'(j));
            chk("t2_d1_hi", do1, 8'h01);
            chk("t2_part_lo", pw0, 1'b1);
            step();
        end
        pop_req = 1'b0;
        chk("t2_empty", e0, 1'b1);

        // 3: full with partial head, push+pop same cycle
        do_reset();
        chk("t3_rst_err", err0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            push_req = 1'b1; data_in = 16'h2000 + 16'(i);
            step();
        end
        push_req = 1'b0; pop_req = 1'b1;
        step();
        chk("t3_part", pw0, 1'b1);
        chk("t3_full_pre", f0, 1'b1);
        push_req = 1'b1; data_in = 16'hBEEF;
        step();
        push_req = 1'b0; pop_req = 1'b0;
        chk("t3_err", err0, 1'b1);
        chk("t3_full", f0, 1'b0);
        chk("t3_af", af0, 1'b1);
        chk("t3_part_end", pw0, 1'b0);
        chk("t3_d0", do0, 8'h20);
        chk("t3_d1", do1, 8'h01);
        pop_req = 1'b1;
        repeat (13) step();
        chk("t3_not_empty", e0, 1'b0);
        chk("t3_last_d0", do0, 8'h07);
        step();
        pop_req = 1'b0;
        chk("t3_empty", e0, 1'b0 == 1'b0);

        // 4: underflow, push+pop on empty, error modes
        do_reset();
        push_req = 1'b1; pop_req = 1'b1; data_in = 16'h4455;
        step();
        push_req = 1'b0; pop_req = 1'b0;
        chk("t4_err0", err0, 1'b1);
        chk("t4_err1", err1, 1'b1);
        chk("t4_empty", e0, 1'b0);
        chk("t4_d0", do0, 8'h44);
        chk("t4_part", pw0, 1'b0);
        step();
        chk("t4_hold0", err0, 1'b1);
        chk("t4_drop1", err1, 1'b0);
        pop_req = 1'b1;
        step();
        step();
        pop_req = 1'b0;
        chk("t4_empty_end", e0, 1'b1);
        chk("t4_hold0_b", err0, 1'b1);
        chk("t4_drop1_b", err1, 1'b0);
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        chk("t4_udf1", err1, 1'b1);
        step();
        chk("t4_udf1_clr", err1, 1'b0);

        // 5: pointer wrap over 12 words
        do_reset();
        for (int i = 0; i < 12; i++) begin
            w = 16'h50A0 + 16'h0101 * 16'(i);
            push_req = 1'b1; data_in = w;
            step();
            push_req = 1'b0; pop_req = 1'b1;
            chk("t5_d0_a", do0, w[15:8]);
            chk("t5_d1_a", do1, w[7:0]);
            step();
            chk("t5_d0_b", do0, w[7:0]);
            chk("t5_d1_b", do1, w[15:8]);
            step();
            pop_req = 1'b0;
        end
        chk("t5_empty", e0, 1'b1);

        // 6: reset with a partially consumed head
        do_reset();
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        chk("t6_err_set", err0, 1'b1);
        push_req = 1'b1; data_in = 16'h6061;
        step();
        data_in = 16'h6263;
        step();
        push_req = 1'b0; pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        chk("t6_part_pre", pw0, 1'b1);
        do_reset();
        chk("t6_empty", e0, 1'b1);
        chk("t6_part", pw0, 1'b0);
        chk("t6_err", err0, 1'b0);
        chk("t6_ae", ae0, 1'b1);
        chk("t6_dout", do0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
